// File: rtl/blink_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : blink_arbiter
//  Description : Fixed-priority arbiter sharing one LED blink generator among
//                NREQ requesters; re-arbitrates only at full-period boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module blink_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] half_period,
    output logic [NREQ-1:0]       grant,
    output logic                  out,
    output logic                  period_done,
    output logic                  busy
);

    localparam logic [0:0]       c_ST_IDLE  = 1'b0;
    localparam logic [0:0]       c_ST_RUN   = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    logic [0:0]       r_state;
    logic [NREQ-1:0]  r_grant;
    logic [CNT_W-1:0] r_hp_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_pd;

    logic             w_found;
    logic [NREQ-1:0]  w_onehot;
    logic [CNT_W-1:0] w_hp_raw;
    logic [CNT_W-1:0] w_hp_sel;
    logic             w_phase_end;

    // Lowest set index wins; its half-period is captured alongside the grant.
    always_comb begin
        w_found  = 1'b0;
        w_onehot = '0;
        w_hp_raw = c_CNT_ZERO;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !w_found) begin
                w_found     = 1'b1;
                w_onehot[i] = 1'b1;
                w_hp_raw    = half_period[i*CNT_W +: CNT_W];
            end
        end
    end

    // A zero half-period would never terminate a phase, so it is promoted to 1.
    assign w_hp_sel    = (w_hp_raw == c_CNT_ZERO) ? c_CNT_ONE : w_hp_raw;
    assign w_phase_end = (r_cnt == (r_hp_q - c_CNT_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_grant <= '0;
            r_hp_q  <= c_CNT_ZERO;
            r_cnt   <= c_CNT_ZERO;
            r_out   <= 1'b0;
            r_pd    <= 1'b0;
        end else begin
            r_pd <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_out   <= 1'b0;
                    r_grant <= '0;
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_hp_q  <= w_hp_sel;
                        r_cnt   <= c_CNT_ZERO;
                        r_out   <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    if (!w_phase_end) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else if (r_out) begin
                        r_cnt <= c_CNT_ZERO;
                        r_out <= 1'b0;
                    end else begin
                        // End of the off-phase: the only point where ownership may change.
                        r_pd  <= 1'b1;
                        r_cnt <= c_CNT_ZERO;
                        if (w_found) begin
                            r_grant <= w_onehot;
                            r_hp_q  <= w_hp_sel;
                            r_out   <= 1'b1;
                        end else begin
                            r_grant <= '0;
                            r_out   <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign out         = r_out;
    assign period_done = r_pd;
    assign busy        = (r_state == c_ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_blink_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blink_arbiter
//  Description : Self-checking bench for blink_arbiter against a period-position
//                reference model, with directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_blink_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 20;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] half_period;
    logic [NREQ-1:0]       grant;
    logic                  out;
    logic                  period_done;
    logic                  busy;

    blink_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .half_period (half_period),
        .grant       (grant),
        .out         (out),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner, its half-period, and position within the 2*hp-cycle period.
    bit m_active;
    int m_owner;
    int m_hp;
    int m_pos;
    bit m_pd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_hp     = 1;
        m_pos    = 0;
        m_pd     = 1'b0;
    endtask

    task automatic model_edge();
        int hpv;
        m_pd = 1'b0;
        if (m_active) begin
            m_pos++;
            if (m_pos == 2 * m_hp) begin
                m_pd     = 1'b1;
                m_active = 1'b0;
            end
        end
        if (!m_active && req != '0) begin
            for (int i = NREQ - 1; i >= 0; i--) if (req[i]) m_owner = i;
            hpv      = int'(half_period[m_owner*CNT_W +: CNT_W]);
            m_hp     = (hpv == 0) ? 1 : hpv;
            m_pos    = 0;
            m_active = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("out", 32'(out), 32'(m_active && (m_pos < m_hp)));
        check("grant", 32'(grant), m_active ? (32'd1 << m_owner) : 32'd0);
        check("busy", 32'(busy), 32'(m_active));
        check("period_done", 32'(period_done), 32'(m_pd));
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic set_hp(input int idx, input int val);
        half_period[idx*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        half_period = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Single requester, hp=5: 5 high / 5 low, pulse every 10 cycles.
        set_hp(0, 5);
        req = 4'b0001;
        step(27);

        // Asynchronous reset mid-period clears outputs without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out", 32'(out), 32'd0);
        check("rst_async_grant", 32'(grant), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_pd", 32'(period_done), 32'd0);
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        req   = 4'b0000;
        step(2);

        // No preemption by a higher index; owner drop still finishes the period.
        set_hp(1, 3);
        req = 4'b0001;
        step(3);
        req = 4'b0011;
        step(3);
        req = 4'b0010;
        step(14);

        // Priority from idle, then lower index takes over at the next boundary.
        req = 4'b0000;
        step(8);
        set_hp(1, 4);
        set_hp(3, 2);
        req = 4'b1010;
        step(3);
        req = 4'b1011;
        step(14);

        // hp=0 and hp=1 toggle every cycle; mid-period hp changes wait for the boundary.
        req = 4'b0000;
        step(12);
        set_hp(0, 0);
        req = 4'b0001;
        step(5);
        set_hp(0, 1);
        step(4);
        set_hp(0, 4);
        step(1);
        set_hp(0, 2);
        step(12);

        // All requests drop mid-period: period completes, then idle.
        step(1);
        req = 4'b0000;
        step(10);

        // Random traffic.
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 7) == 0)
                req = ($urandom_range(0, 3) == 0) ? 4'b0000 : NREQ'($urandom);
            if ($urandom_range(0, 9) == 0)
                set_hp(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 6)));
            if (c == 450) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_rand_out", 32'(out), 32'd0);
                check("rst_rand_busy", 32'(busy), 32'd0);
                model_reset();
                @(negedge clk);
                check_outputs();
                rst_n = 1'b1;
            end
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
